// File: rtl/uc.sv
// Control unit: combinational instruction decode gated by a RUN/HALT/ERROR FSM,
// plus a 16-bit retired-instruction counter.
module uc (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        z,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we,
    output logic        wez,
    output logic [2:0]  ALUOp,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {RUN, HALT, ERROR} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic [2:0] cls, sub;
    logic       dec_s_inc, dec_s_inm, dec_we, dec_wez;
    logic [2:0] dec_aluop;
    logic       dec_halt, dec_illegal;

    assign cls = Opcode[5:3];
    assign sub = Opcode[2:0];

    always_comb begin
        dec_s_inc   = 1'b0;
        dec_s_inm   = 1'b0;
        dec_we      = 1'b0;
        dec_wez     = 1'b0;
        dec_aluop   = 3'b000;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        case (cls)
            3'b000: begin
                dec_we    = 1'b1;
                dec_wez   = 1'b1;
                dec_s_inc = 1'b1;
                dec_aluop = sub;
            end
            3'b001: begin
                dec_we    = 1'b1;
                dec_wez   = 1'b1;
                dec_s_inm = 1'b1;
                dec_s_inc = 1'b1;
                dec_aluop = sub;
            end
            3'b010: begin
                dec_we    = 1'b1;
                dec_s_inm = 1'b1;
                dec_s_inc = 1'b1;
            end
            3'b100: dec_s_inc = 1'b0;
            3'b101: dec_s_inc = ~z;
            3'b110: dec_s_inc = z;
            3'b111: begin
                if (sub == 3'b000) begin
                    dec_s_inc = 1'b1;
                end else if (sub == 3'b111) begin
                    dec_halt = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Outputs: reset forces everything idle; HALT/ERROR park the PC on the self-jump.
    always_comb begin
        s_inc   = 1'b0;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        ALUOp   = 3'b000;
        halted  = 1'b0;
        illegal = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    s_inc = dec_s_inc;
                    s_inm = dec_s_inm;
                    we    = dec_we;
                    wez   = dec_wez;
                    ALUOp = dec_aluop;
                end
                HALT:    halted  = 1'b1;
                ERROR:   illegal = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            if (dec_illegal) begin
                state_d = ERROR;
            end else begin
                cnt_d = cnt_q + 16'd1;
                if (dec_halt) begin
                    state_d = HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc.sv
// Directed bench for uc: a per-cycle behavioural model check plus literal checkpoints.
module tb_uc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = 6'b000000;
    logic        z = 1'b0;
    logic        s_inc, s_inm, we, wez, halted, illegal;
    logic [2:0]  ALUOp;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;

    uc dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
        .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .ALUOp(ALUOp),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = running, 1 = halted, 2 = error.
    int          mode = 0;
    logic [15:0] mcnt = 16'h0000;

    // Instruction kind: 0 alu-reg, 1 alu-imm, 2 li, 3 j, 4 jz, 5 jnz, 6 nop, 7 halt, 8 illegal.
    function automatic int kind_of(input logic [5:0] op);
        int c, s;
        c = int'(op) / 8;
        s = int'(op) % 8;
        if (c == 0) return 0;
        if (c == 1) return 1;
        if (c == 2) return 2;
        if (c == 4) return 3;
        if (c == 5) return 4;
        if (c == 6) return 5;
        if (c == 7 && s == 0) return 6;
        if (c == 7 && s == 7) return 7;
        return 8;
    endfunction

    // Expected {s_inc, s_inm, we, wez, ALUOp[2:0], halted, illegal}.
    function automatic logic [8:0] expect_out(input int md, input logic rst,
                                              input logic [5:0] op, input logic zz);
        int k;
        logic [2:0] s;
        s = op[2:0];
        if (rst) return 9'b0;
        if (md == 1) return 9'b0000_000_10;
        if (md == 2) return 9'b0000_000_01;
        k = kind_of(op);
        case (k)
            0: return {1'b1, 1'b0, 1'b1, 1'b1, s, 2'b00};
            1: return {1'b1, 1'b1, 1'b1, 1'b1, s, 2'b00};
            2: return {1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00};
            4: return {!zz, 8'b0};
            5: return {zz, 8'b0};
            6: return {1'b1, 8'b0};
            default: return 9'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mode <= 0;
            mcnt <= 16'h0000;
        end else if (mode == 0) begin
            if (kind_of(Opcode) == 8) begin
                mode <= 2;
            end else begin
                mcnt <= mcnt + 16'd1;
                if (kind_of(Opcode) == 7) mode <= 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_v, act_v;
        exp_v = expect_out(mode, reset, Opcode, z);
        act_v = {s_inc, s_inm, we, wez, ALUOp, halted, illegal};
        checks++;
        if (act_v !== exp_v || instr_count !== mcnt) begin
            errors++;
            $display("FAIL model op=%b z=%b rst=%b: outputs=%b count=%h, required outputs=%b count=%h",
                     Opcode, z, reset, act_v, instr_count, exp_v, mcnt);
        end
    end

    task automatic apply(input logic [5:0] op, input logic zz, input logic rst);
        @(posedge clk);
        #1;
        Opcode = op;
        z      = zz;
        reset  = rst;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        // Reset priority over HALT and illegal opcodes.
        apply(6'b111111, 1'b0, 1'b1);
        chk("rst_outs", int'({s_inc, s_inm, we, wez, ALUOp, halted, illegal}), 0);
        apply(6'b011000, 1'b0, 1'b1);
        chk("rst_illegal_outs", int'({s_inc, we, illegal}), 0);

        // Decode sweep and branches.
        apply(6'b000011, 1'b0, 1'b0);
        chk("cnt_after_rst", int'(instr_count), 0);
        chk("alu_reg", int'({we, wez, s_inm, s_inc, ALUOp}), 'b1101_011);
        apply(6'b010101, 1'b0, 1'b0);
        chk("li", int'({we, wez, s_inm, ALUOp}), 'b101_000);
        chk("cnt_1", int'(instr_count), 1);
        apply(6'b101000, 1'b1, 1'b0);
        chk("jz_z1", int'(s_inc), 0);
        apply(6'b101000, 1'b0, 1'b0);
        chk("jz_z0", int'(s_inc), 1);
        apply(6'b110000, 1'b0, 1'b0);
        chk("jnz_z0", int'(s_inc), 0);
        apply(6'b110000, 1'b1, 1'b0);
        chk("jnz_z1", int'(s_inc), 1);
        apply(6'b100011, 1'b0, 1'b0);
        chk("j", int'({s_inc, we, ALUOp}), 0);
        apply(6'b001110, 1'b0, 1'b0);
        chk("alu_imm", int'({we, wez, s_inm, s_inc, ALUOp}), 'b1111_110);
        chk("cnt_7", int'(instr_count), 7);

        // Halt after three legal instructions.
        apply(6'b000000, 1'b0, 1'b1);
        apply(6'b000001, 1'b0, 1'b0);
        apply(6'b001010, 1'b0, 1'b0);
        apply(6'b111000, 1'b0, 1'b0);
        chk("nop", int'({s_inc, we, wez}), 'b100);
        apply(6'b111111, 1'b0, 1'b0);
        chk("halt_cycle", int'({s_inc, we, wez, halted}), 0);
        chk("cnt_3", int'(instr_count), 3);
        apply(6'b000011, 1'b0, 1'b0);
        chk("halted", int'({halted, illegal, s_inc, we, wez}), 'b10000);
        chk("halt_cnt", int'(instr_count), 4);
        apply(6'b011000, 1'b1, 1'b0);
        chk("halt_sticky", int'({halted, illegal, s_inc}), 'b100);
        apply(6'b010000, 1'b0, 1'b0);
        chk("halt_cnt_stable", int'(instr_count), 4);

        // Reset out of HALT, then illegal opcode.
        apply(6'b000011, 1'b0, 1'b1);
        apply(6'b000011, 1'b0, 1'b0);
        chk("run_after_halt", int'({halted, we, instr_count}), 'h1_0000);
        apply(6'b011000, 1'b0, 1'b0);
        chk("illegal_cycle", int'({we, wez, s_inc, illegal}), 0);
        chk("illegal_cnt", int'(instr_count), 1);
        apply(6'b000000, 1'b0, 1'b0);
        chk("error", int'({illegal, halted, we}), 'b100);
        chk("error_cnt", int'(instr_count), 1);
        apply(6'b111111, 1'b0, 1'b0);
        chk("error_sticky", int'({illegal, halted}), 'b10);

        // Reset out of ERROR, then illegal cls 111.
        apply(6'b111111, 1'b0, 1'b1);
        apply(6'b111100, 1'b0, 1'b0);
        chk("run_after_error", int'({illegal, instr_count}), 0);
        apply(6'b111000, 1'b0, 1'b0);
        chk("illegal_111", int'(illegal), 1);

        // Counter wrap over 65536 NOPs.
        apply(6'b111000, 1'b0, 1'b1);
        for (int i = 0; i < 65536; i++) apply(6'b111000, 1'b0, 1'b0);
        chk("cnt_ffff", int'(instr_count), 'hFFFF);
        apply(6'b000000, 1'b0, 1'b0);
        chk("cnt_wrap", int'(instr_count), 0);
        chk("wrap_state", int'({halted, illegal, we}), 'b001);

        // Mid-program reset.
        apply(6'b000000, 1'b0, 1'b1);
        apply(6'b010001, 1'b0, 1'b0);
        chk("mid_reset", int'({instr_count, we}), 1);

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
